ps2_edge_conditioner: RTL and testbench
=======================================

Name: ps2_edge_conditioner

Overview:
Multi-channel PS/2 line front end that replaces single-channel falling-edge detection. Per channel it:
- synchronises the raw ps2_clk and ps2_data lines into the clk domain;
- glitch-filters ps2_clk;
- emits single-cycle falling, rising and mode-selected edge strobes;
- captures ps2_data at each filtered falling edge.

It sits between the pins and the keyboard/mouse frame receivers. Channels are fully independent.

Parameters:
CHANNELS, 2, number of independent PS/2 ports
SYNC_STAGES, 2, synchroniser flops per line (min 2)
FILTER_LEN, 8, consecutive cycles a synchronised clk level must differ from the filtered level before the filtered level flips (min 1)
EDGE_MODE, 0, edge_strobe source: 0 = falling, 1 = rising, 2 = both
IDLE_CYCLES, 5000, cycles of filtered-high clk before bus_idle asserts (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ps2_clk  in  CHANNELS  raw PS/2 clock lines, asynchronous
ps2_data  in  CHANNELS  raw PS/2 data lines, asynchronous
clk_level  out  CHANNELS  filtered clock level
falling_edge  out  CHANNELS  1-cycle strobe on filtered 1->0
rising_edge  out  CHANNELS  1-cycle strobe on filtered 0->1
edge_strobe  out  CHANNELS  strobe selected by EDGE_MODE
sampled_data  out  CHANNELS  synchronised data captured on falling edge, held until the next one
bus_idle  out  CHANNELS  clock line idle-high timeout flag

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high. All registers are clk-posedge only.
- Reset values:
  - synchroniser flops = 1 (PS/2 idle-high);
  - clk_level = 1, sampled_data = 1;
  - all strobes = 0, filter counters = 0, idle counters = 0, bus_idle = 0.
- Synchroniser: ps2_clk and ps2_data each pass through SYNC_STAGES flops. sync_clk/sync_data denote the last stage.
- Filter per channel:
  - cnt counts up while sync_clk != clk_level.
  - cnt clears to 0 on any cycle where they are equal.
  - When sync_clk != clk_level and cnt == FILTER_LEN-1, clk_level <= sync_clk and cnt <= 0.
  - Counter width is clog2(FILTER_LEN+1).
- Strobes are registered:
  - falling_edge is high exactly in the first cycle clk_level reads 0; rising_edge likewise for 1.
  - Strobes never last longer than 1 cycle and never assert together.
- Latency: a clean raw transition at cycle T produces the strobe and new clk_level at cycle T+SYNC_STAGES+FILTER_LEN.
- sampled_data is loaded from sync_data in the same cycle the filter commits 1->0, so it is valid coincident with falling_edge. It is unchanged at all other times.
- Glitches shorter than FILTER_LEN synchronised cycles produce no strobe and no level change. A glitch returning mid-count clears the counter, with no partial accumulation.
- Reset mid-operation: all state returns to reset values immediately. If ps2_clk is low through reset, falling_edge fires SYNC_STAGES+FILTER_LEN cycles after reset deasserts.
- EDGE_MODE outside 0..2 behaves as 0.

Optional Feature:
Macro PS2_IDLE_TIMEOUT_EN.
- Defined:
  - a per-channel idle counter, width clog2(IDLE_CYCLES+1), increments while clk_level==1 and saturates at IDLE_CYCLES;
  - the counter clears in any cycle clk_level==0;
  - bus_idle is registered and high while the counter == IDLE_CYCLES, so it rises IDLE_CYCLES cycles after clk_level goes high;
  - bus_idle falls in the same cycle clk_level goes 0.
- Undefined: bus_idle is tied to 0, no counters are instantiated, and IDLE_CYCLES is ignored.

Decomposition:
- Package ps2_pkg holds:
  - edge-mode constants EDGE_FALLING=0, EDGE_RISING=1, EDGE_BOTH=2;
  - PS2_IDLE_LEVEL=1'b1;
  - a clog2 helper function.
- Sub-module ps2_line_filter: one channel's synchroniser, filter, strobes, data capture and optional idle counter.
- Top level generates CHANNELS instances and applies the EDGE_MODE mux.

Test Plan:
(Settings for all cases: CHANNELS=2, SYNC_STAGES=2, FILTER_LEN=4, EDGE_MODE=0.)
1. Release reset at cycle 0, drive ps2_clk[0] low at cycle 10 and hold -> falling_edge[0] and edge_strobe[0] high only at cycle 16; clk_level[0]=0 from 16; channel 1 outputs stay at reset values.
2. ps2_clk[1] low for 3 cycles then high -> no strobe, clk_level[1] stays 1. Repeat with 4 cycles low -> falling_edge[1] once; rising_edge[1] once, 4 cycles after the high transition propagates.
3. ps2_data[0]=0 stable, then clock falls -> sampled_data[0]=0 in the strobe cycle. Set data=1 with no further edge -> sampled_data[0] stays 0.
4. EDGE_MODE=2, ps2_clk[0] square wave with 40-cycle period -> edge_strobe[0] pulses every 20 cycles, each 1 cycle wide; falling_edge and rising_edge alternate.
5. PS2_IDLE_TIMEOUT_EN defined, IDLE_CYCLES=20, ps2_clk high after reset -> bus_idle[0] rises at cycle 20. Drive clock low -> bus_idle[0] clears in the cycle clk_level[0] goes 0. Macro undefined -> bus_idle stays 0 throughout.
6. Hold ps2_clk[0] low, assert reset for 3 cycles mid-stream -> outputs at reset values during reset; falling_edge[0] fires exactly 6 cycles after reset deasserts.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and helpers for the PS/2 line front end.
package ps2_pkg;

  localparam int unsigned EDGE_FALLING = 0;
  localparam int unsigned EDGE_RISING  = 1;
  localparam int unsigned EDGE_BOTH    = 2;

  localparam logic PS2_IDLE_LEVEL = 1'b1;

  // Smallest width able to index 'value' distinct states.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'(1) << result) < 64'(value)) result = result + 1;
    return result;
  endfunction

endpackage

// File: rtl/ps2_edge_conditioner_if.sv
// Pin-side and conditioned-output bundle for all PS/2 channels.
interface ps2_edge_conditioner_if #(
  parameter int unsigned CHANNELS = 2
);

  logic [CHANNELS-1:0] ps2_clk;
  logic [CHANNELS-1:0] ps2_data;
  logic [CHANNELS-1:0] clk_level;
  logic [CHANNELS-1:0] falling_edge;
  logic [CHANNELS-1:0] rising_edge;
  logic [CHANNELS-1:0] edge_strobe;
  logic [CHANNELS-1:0] sampled_data;
  logic [CHANNELS-1:0] bus_idle;

  modport master (
    output ps2_clk, ps2_data,
    input  clk_level, falling_edge, rising_edge, edge_strobe, sampled_data, bus_idle
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output clk_level, falling_edge, rising_edge, edge_strobe, sampled_data, bus_idle
  );

endinterface

// File: rtl/ps2_line_filter.sv
// One PS/2 channel: synchroniser, clock glitch filter, edge strobes, data capture.
// PS2_IDLE_TIMEOUT_EN adds the idle-high timeout counter driving bus_idle.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned IDLE_CYCLES = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_level,
  output logic falling_edge,
  output logic rising_edge,
  output logic sampled_data,
  output logic bus_idle
);

  localparam int unsigned CNT_W = clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   sync_clk;
  logic                   sync_data;
  logic                   mismatch;
  logic                   commit;
  logic                   level_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= {SYNC_STAGES{PS2_IDLE_LEVEL}};
      data_sync_q <= {SYNC_STAGES{PS2_IDLE_LEVEL}};
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Level flips only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    sync_clk  = clk_sync_q[SYNC_STAGES-1];
    sync_data = data_sync_q[SYNC_STAGES-1];
    mismatch  = (sync_clk != clk_level);
    commit    = mismatch && (cnt_q == CNT_W'(FILTER_LEN - 1));
    level_d   = commit ? sync_clk : clk_level;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      clk_level    <= PS2_IDLE_LEVEL;
      falling_edge <= 1'b0;
      rising_edge  <= 1'b0;
      sampled_data <= PS2_IDLE_LEVEL;
    end else begin
      cnt_q        <= (!mismatch || commit) ? '0 : cnt_q + CNT_W'(1);
      clk_level    <= level_d;
      falling_edge <= commit && !sync_clk;
      rising_edge  <= commit && sync_clk;
      if (commit && !sync_clk) sampled_data <= sync_data;
    end
  end

`ifdef PS2_IDLE_TIMEOUT_EN
  localparam int unsigned IDLE_W = clog2(IDLE_CYCLES + 1);

  logic [IDLE_W-1:0] idle_cnt_q;
  logic [IDLE_W-1:0] idle_cnt_d;

  // Saturating count of cycles spent with the filtered clock high.
  always_comb begin
    idle_cnt_d = '0;
    if (clk_level) begin
      idle_cnt_d = (idle_cnt_q == IDLE_W'(IDLE_CYCLES)) ? idle_cnt_q : idle_cnt_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt_q <= '0;
      bus_idle   <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      bus_idle   <= level_d && (idle_cnt_d == IDLE_W'(IDLE_CYCLES));
    end
  end
`else
  assign bus_idle = 1'b0;
`endif

endmodule

// File: rtl/ps2_edge_conditioner.sv
// Multi-channel PS/2 front end: per-channel line filters plus edge_strobe selection.
// Define PS2_IDLE_TIMEOUT_EN to enable the per-channel bus_idle timeout.
module ps2_edge_conditioner
  import ps2_pkg::*;
#(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned EDGE_MODE   = 0,
  parameter int unsigned IDLE_CYCLES = 5000
) (
  input  logic                   clk,
  input  logic                   reset,
  ps2_edge_conditioner_if.slave  bus
);

  localparam int unsigned MODE = (EDGE_MODE > EDGE_BOTH) ? EDGE_FALLING : EDGE_MODE;

  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] sdata;
  logic [CHANNELS-1:0] idle;
  logic [CHANNELS-1:0] strobe;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    ps2_line_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .IDLE_CYCLES (IDLE_CYCLES)
    ) u_filter (
      .clk          (clk),
      .reset        (reset),
      .ps2_clk      (bus.ps2_clk[ch]),
      .ps2_data     (bus.ps2_data[ch]),
      .clk_level    (level[ch]),
      .falling_edge (fall[ch]),
      .rising_edge  (rise[ch]),
      .sampled_data (sdata[ch]),
      .bus_idle     (idle[ch])
    );
  end

  // Strobes are already registered; this is a static select between them.
  always_comb begin
    strobe = fall;
    case (MODE)
      EDGE_RISING: strobe = rise;
      EDGE_BOTH:   strobe = fall | rise;
      default:     strobe = fall;
    endcase
  end

  assign bus.clk_level    = level;
  assign bus.falling_edge = fall;
  assign bus.rising_edge  = rise;
  assign bus.edge_strobe  = strobe;
  assign bus.sampled_data = sdata;
  assign bus.bus_idle     = idle;

endmodule

// File: tb/tb_ps2_edge_conditioner.sv
// Scoreboard bench: directed and random pin activity against a window-based line model.
module tb_ps2_edge_conditioner;

  localparam int unsigned CH    = 2;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned FL    = 4;
  localparam int unsigned IDLE  = 20;
  localparam int          NMODE = 4;
  localparam int          HIST  = SYNC + FL;

  typedef struct {
    int          k;
    logic [CH-1:0] lvl;
    logic [CH-1:0] fe;
    logic [CH-1:0] re;
    logic [CH-1:0] sd;
    logic [CH-1:0] bi;
  } snap_t;

  typedef struct {
    int   k;
    logic fall;
    logic data;
  } evt_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] raw_clk;
  logic [CH-1:0] raw_data;
  int            edge_no = 0;
  int            total = 0;
  int            bad = 0;

  logic [CH-1:0] lvl_o [NMODE];
  logic [CH-1:0] fe_o  [NMODE];
  logic [CH-1:0] re_o  [NMODE];
  logic [CH-1:0] es_o  [NMODE];
  logic [CH-1:0] sd_o  [NMODE];
  logic [CH-1:0] bi_o  [NMODE];

  always #5 clk = ~clk;
  always @(posedge clk) edge_no <= edge_no + 1;

  for (genvar m = 0; m < NMODE; m++) begin : g_dut
    ps2_edge_conditioner_if #(.CHANNELS(CH)) bus ();
    assign bus.ps2_clk  = raw_clk;
    assign bus.ps2_data = raw_data;
    ps2_edge_conditioner #(
      .CHANNELS    (CH),
      .SYNC_STAGES (SYNC),
      .FILTER_LEN  (FL),
      .EDGE_MODE   (m),
      .IDLE_CYCLES (IDLE)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );
    assign lvl_o[m] = bus.clk_level;
    assign fe_o[m]  = bus.falling_edge;
    assign re_o[m]  = bus.rising_edge;
    assign es_o[m]  = bus.edge_strobe;
    assign sd_o[m]  = bus.sampled_data;
    assign bi_o[m]  = bus.bus_idle;
  end

  // Reference model state: recent raw samples per channel, as the filter would see them.
  logic  hist_c [CH][$];
  logic  hist_d [CH][$];
  logic  m_lvl  [CH];
  logic  m_sd   [CH];
  int    m_idle [CH];
  snap_t snap_q [$];
  evt_t  evt_q  [CH][$];

  task automatic chk(input string name, input int m, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s mode=%0d cycle=%0d got=%0h want=%0h", name, m, edge_no, act, exp);
    end
  endtask

  task automatic model_reset_ch(input int ch);
    hist_c[ch].delete();
    hist_d[ch].delete();
    for (int i = 0; i < HIST; i++) begin
      hist_c[ch].push_back(1'b1);
      hist_d[ch].push_back(1'b1);
    end
    m_lvl[ch]  = 1'b1;
    m_sd[ch]   = 1'b1;
    m_idle[ch] = 0;
  endtask

  // Level after edge k flips iff the FL samples seen through the synchroniser all disagree with it.
  task automatic model_edge(input int k);
    snap_t s;
    evt_t  e;
    bit    flip;
    logic  old;
    s.k = k; s.lvl = '0; s.fe = '0; s.re = '0; s.sd = '0; s.bi = '0;
    for (int ch = 0; ch < CH; ch++) begin
      if (reset) begin
        model_reset_ch(ch);
      end else begin
        hist_c[ch].push_back(raw_clk[ch]);
        hist_d[ch].push_back(raw_data[ch]);
        void'(hist_c[ch].pop_front());
        void'(hist_d[ch].pop_front());
        flip = 1'b1;
        for (int i = 0; i < FL; i++)
          if (hist_c[ch][HIST-1-SYNC-i] == m_lvl[ch]) flip = 1'b0;
        old = m_lvl[ch];
        if (flip) begin
          m_lvl[ch] = ~m_lvl[ch];
          e.k    = k;
          e.fall = ~m_lvl[ch];
          e.data = hist_d[ch][HIST-1-SYNC];
          if (e.fall) begin
            m_sd[ch]  = e.data;
            s.fe[ch]  = 1'b1;
          end else begin
            s.re[ch]  = 1'b1;
          end
          evt_q[ch].push_back(e);
        end
        m_idle[ch] = old ? ((m_idle[ch] < int'(IDLE)) ? m_idle[ch] + 1 : m_idle[ch]) : 0;
      end
      s.lvl[ch] = m_lvl[ch];
      s.sd[ch]  = m_sd[ch];
`ifdef PS2_IDLE_TIMEOUT_EN
      s.bi[ch]  = m_lvl[ch] && (m_idle[ch] == int'(IDLE));
`endif
    end
    snap_q.push_back(s);
  endtask

  function automatic logic [CH-1:0] exp_es(input int m, input snap_t s);
    if (m == 1) return s.re;
    if (m == 2) return s.fe | s.re;
    return s.fe;
  endfunction

  task automatic step(input logic r, input logic [CH-1:0] c, input logic [CH-1:0] d);
    @(negedge clk);
    reset    = r;
    raw_clk  = c;
    raw_data = d;
    model_edge(edge_no + 1);
  endtask

  // Monitor: per-cycle snapshot compare plus strobe-driven event scoreboard.
  always @(posedge clk) begin
    snap_t cur;
    evt_t  e;
    #1;
    while (snap_q.size() > 0 && snap_q[0].k < edge_no) void'(snap_q.pop_front());
    if (snap_q.size() > 0 && snap_q[0].k == edge_no) begin
      cur = snap_q.pop_front();
      for (int m = 0; m < NMODE; m++) begin
        chk("clk_level",    m, int'(lvl_o[m]), int'(cur.lvl));
        chk("falling_edge", m, int'(fe_o[m]),  int'(cur.fe));
        chk("rising_edge",  m, int'(re_o[m]),  int'(cur.re));
        chk("edge_strobe",  m, int'(es_o[m]),  int'(exp_es(m, cur)));
        chk("sampled_data", m, int'(sd_o[m]),  int'(cur.sd));
        chk("bus_idle",     m, int'(bi_o[m]),  int'(cur.bi));
      end
    end
    for (int ch = 0; ch < CH; ch++) begin
      if (fe_o[0][ch] || re_o[0][ch]) begin
        if (evt_q[ch].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe ch=%0d cycle=%0d got=strobe want=none", ch, edge_no);
        end else begin
          e = evt_q[ch].pop_front();
          chk("event_cycle", ch, edge_no, e.k);
          chk("event_kind",  ch, int'(fe_o[0][ch]), int'(e.fall));
          if (e.fall) chk("event_data", ch, int'(sd_o[0][ch]), int'(e.data));
        end
      end
      while (evt_q[ch].size() > 0 && evt_q[ch][0].k < edge_no) begin
        total++;
        bad++;
        $display("FAIL missing_strobe ch=%0d cycle=%0d got=none want_cycle=%0d", ch, edge_no, evt_q[ch][0].k);
        void'(evt_q[ch].pop_front());
      end
    end
  end

  initial begin
    logic [CH-1:0] c;
    logic [CH-1:0] d;
    int            run [CH];
    reset    = 1'b1;
    raw_clk  = '1;
    raw_data = '1;
    for (int ch = 0; ch < CH; ch++) model_reset_ch(ch);
    repeat (3) step(1'b1, '1, '1);

    // Clean fall and rise on channel 0
    repeat (10) step(1'b0, 2'b11, 2'b11);
    repeat (12) step(1'b0, 2'b10, 2'b11);
    repeat (12) step(1'b0, 2'b11, 2'b11);

    // Channel 1: 3-cycle glitch rejected, 4-cycle low accepted
    repeat (3)  step(1'b0, 2'b01, 2'b11);
    repeat (10) step(1'b0, 2'b11, 2'b11);
    repeat (4)  step(1'b0, 2'b01, 2'b11);
    repeat (12) step(1'b0, 2'b11, 2'b11);

    // Data capture on channel 0, then data change without an edge
    repeat (6)  step(1'b0, 2'b11, 2'b10);
    repeat (10) step(1'b0, 2'b10, 2'b10);
    repeat (10) step(1'b0, 2'b10, 2'b11);
    repeat (10) step(1'b0, 2'b11, 2'b11);

    // 40-cycle square wave on channel 0
    for (int h = 0; h < 8; h++) repeat (20) step(1'b0, (h % 2 == 0) ? 2'b10 : 2'b11, 2'b11);

    // Long high for the idle timeout, then a low period
    repeat (30) step(1'b0, 2'b11, 2'b11);
    repeat (10) step(1'b0, 2'b10, 2'b11);
    repeat (30) step(1'b0, 2'b11, 2'b11);

    // Reset mid-stream while channel 0 is held low
    repeat (10) step(1'b0, 2'b10, 2'b11);
    repeat (3)  step(1'b1, 2'b10, 2'b11);
    repeat (12) step(1'b0, 2'b10, 2'b11);
    repeat (12) step(1'b0, 2'b11, 2'b11);

    // Random runs around the filter length, random data, occasional reset
    c = '1;
    d = '1;
    for (int ch = 0; ch < CH; ch++) run[ch] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < CH; ch++) begin
        if (run[ch] == 0) begin
          c[ch]   = ~c[ch];
          run[ch] = $urandom_range(1, 10);
        end
        run[ch] = run[ch] - 1;
        if ($urandom_range(0, 3) == 0) d[ch] = ~d[ch];
      end
      step(($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0, c, d);
    end

    repeat (SYNC + FL + 4) step(1'b0, '1, '1);
    @(posedge clk);
    #2;
    for (int ch = 0; ch < CH; ch++) chk("pending_events", ch, evt_q[ch].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
